// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-organised data memory.
// Loads are lane-selected and extended. Sub-word stores are done as a
// read-modify-write, so the memory only ever sees whole 32-bit words.
module load_store_unit #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_RESP
  } state_t;

  state_t state, state_nx;

  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;   // only the sub-word lanes are needed after accept
  logic              accept;
  logic              req_err;
  logic              illegal;
  logic              misaligned;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  assign accept     = req_valid && req_ready;
  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign mem_addr   = addr_q[ADDR_W-1:2];

  // Request legality: illegal funct3 encodings and natural-alignment violations.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (req_is_store) begin
      illegal = req_funct3[2];
    end else begin
      illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
    if (req_funct3[1]) begin
      misaligned = (req_addr[1:0] != 2'b00);
    end else if (req_funct3[0]) begin
      misaligned = req_addr[0];
    end
    req_err = illegal || misaligned;
  end

  // Lane selection and extension of the memory word for loads.
  always_comb begin
    byte_sel  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = '0;
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = mem_rdata;
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = '0;
    endcase
  end

  // Merge of sub-word store data into the old memory word.
  always_comb begin
    merged = mem_rdata;
    if (funct3_q[0]) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Write enable decoded from registered state only, so it is stable
  // across the falling edge where the memory commits.
  always_comb begin
    mem_we = 1'b0;
    if (state == S_WRITE) begin
      mem_we = 1'b1;
    end else if ((state == S_ACCESS) && is_store_q && funct3_q[1]) begin
      mem_we = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = req_err ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_nx = (is_store_q && !funct3_q[1]) ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        state_nx = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Request capture, load result and write-data registers.
  // The outgoing write word is registered one step early (at accept for SW,
  // at the read step for SB/SH) so mem_wdata is a plain register that
  // naturally holds its last value outside the write cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata[15:0];
            resp_rdata <= '0;
            resp_err   <= req_err;
            if (!req_err && req_is_store && req_funct3[1]) begin
              mem_wdata <= req_wdata;
            end
          end
        end
        S_ACCESS: begin
          if (!is_store_q) begin
            resp_rdata <= load_data;
          end else if (!funct3_q[1]) begin
            mem_wdata <= merged;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:16383];
  logic [31:0] ref_mem [0:15];
  int          we_pulses = 0;
  int          passed = 0;
  int          total = 0;

  load_store_unit #(.ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write at the falling edge.
  assign mem_rdata = mem[mem_addr];
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr] = mem_wdata;
      we_pulses = we_pulses + 1;
    end
  end

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_err(input bit st, input logic [2:0] f3, input logic [15:0] a);
    bit bad;
    bad = st ? f3[2] : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    return bad || ((int'(a) % m_size(f3)) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [15:0] a);
    logic [63:0] v;
    logic [63:0] mask;
    int sz;
    sz   = m_size(f3);
    mask = (64'd1 << (8 * sz)) - 64'd1;
    v    = (64'(ref_mem[a[5:2]]) >> (8 * (int'(a) % 4))) & mask;
    if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic m_store(input logic [15:0] a, input logic [31:0] wd, input int sz);
    logic [31:0] w;
    int pos;
    w = ref_mem[a[5:2]];
    for (int i = 0; i < sz; i++) begin
      pos = (int'(a) % 4) + i;
      w[8 * pos +: 8] = wd[8 * i +: 8];
    end
    ref_mem[a[5:2]] = w;
  endtask

  // One complete transaction; returns latency (edges from accept, inclusive),
  // response data/error and the number of memory write pulses it caused.
  task automatic do_req(input bit st, input logic [2:0] f3, input logic [15:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic er, output int wes);
    int w0;
    w0 = we_pulses;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    wes = we_pulses - w0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else passed++;
    total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid); else passed++;
    total++; if (resp_rdata !== 32'd0) $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); else passed++;
    total++; if (resp_err !== 1'b0) $display("FAIL reset_resp_err got %b want 0", resp_err); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", mem_we); else passed++;
    total++; if (mem_addr !== 14'd0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'd0) $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b010};
    logic [15:0] adrs [4] = '{16'h0040, 16'h0040, 16'h0042, 16'h0040};
    logic [31:0] exps [4] = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'hFFFF_8765, 32'h8765_43F1};
    int lat, wes; logic [31:0] rd; logic er;
    mem[16'h10] = 32'h8765_43F1;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, f3s[i], adrs[i], 32'h0, lat, rd, er, wes);
      total++; if (rd !== exps[i]) $display("FAIL load%0d_rdata got %h want %h", i, rd, exps[i]); else passed++;
      total++; if (er !== 1'b0) $display("FAIL load%0d_err got %b want 0", i, er); else passed++;
      total++; if (lat != 2) $display("FAIL load%0d_latency got %0d want 2", i, lat); else passed++;
    end
  endtask

  task automatic test_stores();
    int lat, wes; logic [31:0] rd; logic er;
    mem[16'h10] = 32'h1122_3344;
    do_req(1'b1, 3'b000, 16'h0041, 32'h0000_00AB, lat, rd, er, wes);
    total++; if (mem[16'h10] !== 32'h1122_AB44) $display("FAIL sb_word got %h want 1122ab44", mem[16'h10]); else passed++;
    total++; if (lat != 3) $display("FAIL sb_latency got %0d want 3", lat); else passed++;
    total++; if (wes != 1) $display("FAIL sb_we_pulses got %0d want 1", wes); else passed++;
    total++; if (rd !== 32'd0 || er !== 1'b0) $display("FAIL sb_resp got %h/%b want 0/0", rd, er); else passed++;
    do_req(1'b1, 3'b001, 16'h0042, 32'h0000_CDEF, lat, rd, er, wes);
    total++; if (mem[16'h10] !== 32'hCDEF_AB44) $display("FAIL sh_word got %h want cdefab44", mem[16'h10]); else passed++;
    total++; if (lat != 3) $display("FAIL sh_latency got %0d want 3", lat); else passed++;
    total++; if (wes != 1) $display("FAIL sh_we_pulses got %0d want 1", wes); else passed++;
    mem[16'h11] = 32'h0;
    do_req(1'b1, 3'b010, 16'h0044, 32'hDEAD_BEEF, lat, rd, er, wes);
    total++; if (mem[16'h11] !== 32'hDEAD_BEEF) $display("FAIL sw_word got %h want deadbeef", mem[16'h11]); else passed++;
    total++; if (lat != 2) $display("FAIL sw_latency got %0d want 2", lat); else passed++;
    total++; if (wes != 1) $display("FAIL sw_we_pulses got %0d want 1", wes); else passed++;
  endtask

  task automatic test_errors();
    int lat, wes; logic [31:0] rd; logic er;
    mem[16'h10] = 32'h1122_3344;
    do_req(1'b0, 3'b010, 16'h0041, 32'h0, lat, rd, er, wes);
    total++; if (er !== 1'b1) $display("FAIL lw_misalign_err got %b want 1", er); else passed++;
    total++; if (rd !== 32'd0) $display("FAIL lw_misalign_rdata got %h want 0", rd); else passed++;
    total++; if (lat != 1) $display("FAIL lw_misalign_latency got %0d want 1", lat); else passed++;
    do_req(1'b1, 3'b001, 16'h0043, 32'h0000_5555, lat, rd, er, wes);
    total++; if (er !== 1'b1) $display("FAIL sh_misalign_err got %b want 1", er); else passed++;
    total++; if (wes != 0) $display("FAIL sh_misalign_we got %0d want 0", wes); else passed++;
    total++; if (mem[16'h10] !== 32'h1122_3344) $display("FAIL sh_misalign_mem got %h want 11223344", mem[16'h10]); else passed++;
    do_req(1'b0, 3'b011, 16'h0040, 32'h0, lat, rd, er, wes);
    total++; if (er !== 1'b1) $display("FAIL load_f3_011_err got %b want 1", er); else passed++;
    do_req(1'b1, 3'b100, 16'h0040, 32'h0, lat, rd, er, wes);
    total++; if (er !== 1'b1 || wes != 0) $display("FAIL store_f3_100 got err %b we %0d want 1/0", er, wes); else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int w0;
    mem[16'h12] = 32'hA5A5_5A5A;
    w0 = we_pulses;
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 16'h0048; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b1) $display("FAIL bp_resp_valid_rise got %b want 1", resp_valid); else passed++;
    held = resp_rdata;
    for (int i = 0; i < 5; i++) begin
      total++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hA5A5_5A5A || req_ready !== 1'b0)
        $display("FAIL bp_hold%0d got valid %b data %h ready %b want 1 a5a55a5a 0", i, resp_valid, resp_rdata, req_ready);
      else passed++;
      if (i == 2) begin
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 16'h0048; req_wdata = 32'h0;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    total++; if (resp_rdata !== held) $display("FAIL bp_data_stable got %h want %h", resp_rdata, held); else passed++;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL bp_release got ready %b valid %b want 1/0", req_ready, resp_valid); else passed++;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) $display("FAIL bp_no_stale_accept got ready %b want 1", req_ready); else passed++;
    total++; if (mem[16'h12] !== 32'hA5A5_5A5A || we_pulses != w0) $display("FAIL bp_ignored_store got %h we %0d want a5a55a5a 0", mem[16'h12], we_pulses - w0); else passed++;
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b1;
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 16'h0050; req_wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b0 || mem_we !== 1'b1) $display("FAIL b2b_access got ready %b we %b want 0/1", req_ready, mem_we); else passed++;
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b1 || req_ready !== 1'b0 || mem_we !== 1'b0) $display("FAIL b2b_resp got valid %b ready %b we %b want 1/0/0", resp_valid, req_ready, mem_we); else passed++;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL b2b_ready_again got ready %b valid %b want 1/0", req_ready, resp_valid); else passed++;
    total++; if (mem[16'h14] !== 32'h0BAD_F00D) $display("FAIL b2b_mem got %h want 0badf00d", mem[16'h14]); else passed++;
    resp_ready = 1'b0;
  endtask

  task automatic test_random();
    int lat, wes, sz, elat;
    logic [31:0] rd, exp_rd, wd;
    logic er;
    bit st, exp_err;
    logic [2:0] f3;
    logic [15:0] a;
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom();
      ref_mem[i] = mem[i];
    end
    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom_range(0, 1));
      if (st) f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 2));
      else    f3 = 3'($urandom_range(0, 7));
      sz = m_size(f3);
      a  = 16'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~16'(sz - 1);
      wd = $urandom();
      exp_err = m_err(st, f3, a);
      exp_rd  = (st || exp_err) ? 32'd0 : m_load(f3, a);
      elat    = exp_err ? 1 : ((st && sz < 4) ? 3 : 2);
      if (st && !exp_err) m_store(a, wd, sz);
      do_req(st, f3, a, wd, lat, rd, er, wes);
      total++; if (er !== exp_err) $display("FAIL rnd%0d_err st %0d f3 %0d a %h got %b want %b", n, st, f3, a, er, exp_err); else passed++;
      total++; if (rd !== exp_rd) $display("FAIL rnd%0d_rdata f3 %0d a %h got %h want %h", n, f3, a, rd, exp_rd); else passed++;
      total++; if (lat != elat) $display("FAIL rnd%0d_latency got %0d want %0d", n, lat, elat); else passed++;
      total++; if (wes != ((st && !exp_err) ? 1 : 0)) $display("FAIL rnd%0d_we_pulses got %0d want %0d", n, wes, (st && !exp_err) ? 1 : 0); else passed++;
      total++; if (mem[a[5:2]] !== ref_mem[a[5:2]]) $display("FAIL rnd%0d_mem a %h got %h want %h", n, a, mem[a[5:2]], ref_mem[a[5:2]]); else passed++;
    end
  endtask

  task automatic test_reset_mid_write();
    mem[16'h10] = 32'h1122_3344;
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000; req_addr = 16'h0040; req_wdata = 32'h0000_00FF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (mem_we !== 1'b1) $display("FAIL rst_write_phase_we got %b want 1", mem_we); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0) $display("FAIL rst_we_drop got %b want 0", mem_we); else passed++;
    @(negedge clk); #1;
    total++; if (mem[16'h10] !== 32'h1122_3344) $display("FAIL rst_mem_unchanged got %h want 11223344", mem[16'h10]); else passed++;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0)
      $display("FAIL rst_resp_outputs got ready %b valid %b data %h err %b want 1/0/0/0", req_ready, resp_valid, resp_rdata, resp_err);
    else passed++;
    total++; if (mem_addr !== 14'd0 || mem_wdata !== 32'd0) $display("FAIL rst_mem_outputs got addr %h wdata %h want 0/0", mem_addr, mem_wdata); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL rst_after_release got ready %b valid %b want 1/0", req_ready, resp_valid); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    mem[0] = 32'h0;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
